sfq_or_deser: RTL and testbench

//  Downstream consumer of the clocked SFQ OR cell. It converts the OR output

---
 rtl/sfq_cells_pkg.sv | 24 ++
 rtl/sfq_tgl_edge.sv | 18 +
 rtl/sfq_or_deser.sv | 108 ++++++++++
 tb/tb_sfq_or_deser.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sfq_cells_pkg.sv
// Shared definitions for the SFQ readout cells: holding-FSM states,
// counter width and a constant log2 helper for parameter checks.
package sfq_cells_pkg;

   localparam int CNT_W = 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } hold_state_t;

   function automatic int clog2(input int unsigned value);
      int unsigned x;
      int          r;
      x = (value > 0) ? value - 1 : 0;
      r = 0;
      while (x != 0) begin
         x = x >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sfq_tgl_edge.sv
// Converts a toggle-encoded SFQ line into a one-cycle pulse per transition.
// The level seen during reset is captured so it never reads as a pulse.
module sfq_tgl_edge (
   input  logic clk,
   input  logic rst,
   input  logic tgl_i,
   output logic pulse_o
);

   logic prev;

   always_ff @(posedge clk) begin
      prev <= tgl_i;
   end

   assign pulse_o = rst ? 1'b0 : (tgl_i ^ prev);

endmodule

// File: rtl/sfq_or_deser.sv
// Deserialises the toggle-encoded SFQ OR output into WIDTH-bit words and
// offers each completed word on a valid/ready handshake with overrun flag.
module sfq_or_deser
   import sfq_cells_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sfq_in,
   input  logic             sample_en,
   output logic [WIDTH-1:0] word_o,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [4:0]       bit_cnt,
   output logic             overrun
);

   // Legal WIDTH is 2..32; anything wider than the counter can count is clamped.
   localparam bit WIDTH_OK = (WIDTH >= 2) && (clog2(WIDTH) <= CNT_W);
   localparam logic [CNT_W-1:0] LAST = WIDTH_OK ? CNT_W'(WIDTH - 1) : '1;

   hold_state_t      state, state_next;
   logic             pulse;
   logic [WIDTH-1:0] sr, sr_next;
   logic [CNT_W-1:0] cnt;
   logic             complete;
   logic             load;
   logic             overrun_set;

   sfq_tgl_edge u_edge (
      .clk     (clk),
      .rst     (rst),
      .tgl_i   (sfq_in),
      .pulse_o (pulse)
   );

   always_comb begin
      sr_next = sr;
      if (MSB_FIRST) begin
         sr_next = {sr[WIDTH-2:0], pulse};
      end else begin
         sr_next = {pulse, sr[WIDTH-1:1]};
      end
   end

   assign complete = sample_en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      load        = 1'b0;
      overrun_set = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (complete) begin
               load       = 1'b1;
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (word_ready) begin
               // Accept and refill in one cycle keeps back-to-back words bubble-free.
               if (complete) begin
                  load = 1'b1;
               end else begin
                  state_next = ST_EMPTY;
               end
            end else if (complete) begin
               overrun_set = 1'b1;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr      <= '0;
         cnt     <= '0;
         word_o  <= '0;
         overrun <= 1'b0;
      end else begin
         if (sample_en) begin
            sr  <= sr_next;
            cnt <= complete ? '0 : cnt + 1'b1;
         end
         if (load) begin
            word_o <= sr_next;
         end
         if (overrun_set) begin
            overrun <= 1'b1;
         end
      end
   end

   assign word_valid = (state == ST_FULL);
   assign bit_cnt    = cnt;

endmodule

// File: tb/tb_sfq_or_deser.sv
// Directed bench for sfq_or_deser (WIDTH=8, LSB first); accepted words are
// checked against a queue of expected words pushed as each word is driven.
module tb_sfq_or_deser;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         sfq_in;
   logic         sample_en;
   logic [W-1:0] word_o;
   logic         word_valid;
   logic         word_ready;
   logic [4:0]   bit_cnt;
   logic         overrun;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [W-1:0] exp_q[$];

   sfq_or_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .sfq_in     (sfq_in),
      .sample_en  (sample_en),
      .word_o     (word_o),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .bit_cnt    (bit_cnt),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock period: a 1 toggles the line, en qualifies the period.
   task automatic send_bit(input logic b, input logic en);
      sfq_in    = sfq_in ^ b;
      sample_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) send_bit(w[i], 1'b1);
      sample_en = 1'b0;
   endtask

   task automatic idle();
      send_bit(1'b0, 1'b0);
   endtask

   // Scoreboard: every handshake must deliver the oldest expected word.
   always @(negedge clk) begin
      if (!rst && word_valid && word_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_accept", {24'h0, word_o}, 32'hDEAD);
         end else begin
            chk("accepted_word", {24'h0, word_o}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst = 1'b1; sfq_in = 1'b1; sample_en = 1'b0; word_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bit_cnt", {27'h0, bit_cnt}, 32'd0);
      chk("rst_valid", {31'h0, word_valid}, 32'd0);
      chk("rst_overrun", {31'h0, overrun}, 32'd0);
      chk("rst_word", {24'h0, word_o}, 32'h00);

      // 1: line held high through reset release reads as all zeros
      rst = 1'b0;
      exp_q.push_back(8'h00);
      for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
      chk("t1_cnt7", {27'h0, bit_cnt}, 32'd7);
      chk("t1_valid_before", {31'h0, word_valid}, 32'd0);
      send_bit(1'b0, 1'b1);
      sample_en = 1'b0;
      chk("t1_valid_latency", {31'h0, word_valid}, 32'd1);
      chk("t1_word", {24'h0, word_o}, 32'h00);
      chk("t1_cnt_wrap", {27'h0, bit_cnt}, 32'd0);
      word_ready = 1'b1;
      idle();
      chk("t1_drained", {31'h0, word_valid}, 32'd0);

      // 2: pulses on sampled periods 0, 2, 7
      exp_q.push_back(8'h85);
      send_word(8'h85);
      chk("t2_valid", {31'h0, word_valid}, 32'd1);
      chk("t2_word", {24'h0, word_o}, 32'h85);
      chk("t2_overrun", {31'h0, overrun}, 32'd0);
      idle();
      chk("t2_valid_one_cycle", {31'h0, word_valid}, 32'd0);

      // 3: toggles while sample_en=0 contribute nothing
      exp_q.push_back(8'h2F);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
      chk("t3_cnt4", {27'h0, bit_cnt}, 32'd4);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      chk("t3_cnt_hold", {27'h0, bit_cnt}, 32'd4);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      sample_en = 1'b0;
      chk("t3_word", {24'h0, word_o}, 32'h2F);
      idle();
      chk("t3_drained", {31'h0, word_valid}, 32'd0);

      // 5: accept and completion in the same cycle
      word_ready = 1'b0;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_word(8'h11);
      chk("t5_first_valid", {31'h0, word_valid}, 32'd1);
      for (int i = 0; i < W - 1; i++) send_bit(W'(8'h22) >> i, 1'b1);
      word_ready = 1'b1;
      send_bit(1'b0, 1'b1);
      sample_en = 1'b0;
      chk("t5_valid_stays", {31'h0, word_valid}, 32'd1);
      chk("t5_new_word", {24'h0, word_o}, 32'h22);
      chk("t5_overrun", {31'h0, overrun}, 32'd0);
      idle();
      chk("t5_drained", {31'h0, word_valid}, 32'd0);

      // 4: ready low across two words
      word_ready = 1'b0;
      exp_q.push_back(8'hA5);
      send_word(8'hA5);
      chk("t4_first_word", {24'h0, word_o}, 32'hA5);
      chk("t4_no_overrun_yet", {31'h0, overrun}, 32'd0);
      send_word(8'h3C);
      chk("t4_word_held", {24'h0, word_o}, 32'hA5);
      chk("t4_valid_held", {31'h0, word_valid}, 32'd1);
      chk("t4_overrun", {31'h0, overrun}, 32'd1);
      word_ready = 1'b1;
      idle();
      chk("t4_drained", {31'h0, word_valid}, 32'd0);
      chk("t4_overrun_sticky", {31'h0, overrun}, 32'd1);

      // 6: reset mid-word discards the partial word
      for (int i = 0; i < 5; i++) send_bit(i[0], 1'b1);
      chk("t6_cnt5", {27'h0, bit_cnt}, 32'd5);
      rst = 1'b1;
      idle();
      chk("t6_rst_cnt", {27'h0, bit_cnt}, 32'd0);
      chk("t6_rst_valid", {31'h0, word_valid}, 32'd0);
      chk("t6_rst_overrun", {31'h0, overrun}, 32'd0);
      rst = 1'b0;
      exp_q.push_back(8'hC3);
      send_word(8'hC3);
      chk("t6_fresh_word", {24'h0, word_o}, 32'hC3);
      idle();
      chk("t6_drained", {31'h0, word_valid}, 32'd0);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
